// File: rtl/fb_scanout.sv
// 640x480@60 raster generator and framebuffer scanout with 2x horizontal/vertical doubling.
// Three stages: raster counters -> framebuffer read issue -> RGB888 expansion and sync outputs.
module fb_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned FB_WIDTH = H_ACTIVE / 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output logic [16:0] fb_addr_o,
  output logic        fb_rd_o,
  input  logic [15:0] fb_dat_i,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = 17;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic frame;
  } timing_t;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] line_base;
  logic          h_last_c;
  logic          v_last_c;
  timing_t       s0_c;
  timing_t       s1;
  logic [4:0]    r5_c;
  logic [5:0]    g6_c;
  logic [4:0]    b5_c;

  assign h_last_c = (hcnt == HW'(H_TOTAL - 1));
  assign v_last_c = (vcnt == VW'(V_TOTAL - 1));
  assign {r5_c, g6_c, b5_c} = fb_dat_i;

  // Raster counters; line_base steps once per source line, i.e. after every odd visible line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_base <= '0;
    end else if (h_last_c) begin
      hcnt <= '0;
      if (v_last_c) begin
        vcnt      <= '0;
        line_base <= '0;
      end else begin
        vcnt <= vcnt + VW'(1);
        if (vcnt[0] && (vcnt < VW'(V_ACTIVE))) begin
          line_base <= line_base + AW'(FB_WIDTH);
        end
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Stage-0 timing decode from the raw counters
  always_comb begin
    s0_c        = '0;
    s0_c.active = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    s0_c.hsync  = (hcnt >= HW'(HS_BEG)) && (hcnt < HW'(HS_END));
    s0_c.vsync  = (vcnt >= VW'(VS_BEG)) && (vcnt < VW'(VS_END));
    s0_c.frame  = (hcnt == '0) && (vcnt == VW'(V_ACTIVE));
  end

  // Stage 1: read issue; hcnt/2 repeats each source pixel across two output pixels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fb_addr_o <= '0;
      fb_rd_o   <= 1'b0;
      s1        <= '0;
    end else begin
      fb_addr_o <= line_base + AW'(hcnt >> 1);
      fb_rd_o   <= s0_c.active & enable_i;
      s1        <= s0_c;
    end
  end

  // Stage 2: BRAM data arrives here; enable also masks pixels already in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      de_o    <= 1'b0;
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
      frame_o <= 1'b0;
    end else begin
      de_o    <= s1.active;
      hsync_o <= s1.hsync ? SYNC_POL : ~SYNC_POL;
      vsync_o <= s1.vsync ? SYNC_POL : ~SYNC_POL;
      frame_o <= s1.frame;
      if (s1.active && enable_i) begin
        red_o   <= {r5_c, r5_c[4:2]};
        green_o <= {g6_c, g6_c[5:4]};
        blue_o  <= {b5_c, b5_c[4:2]};
      end else begin
        red_o   <= '0;
        green_o <= '0;
        blue_o  <= '0;
      end
    end
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Video scanout engine that reads the 320x240 RGB565 framebuffer written by the TIA pixel writer and drives a 640x480@60 raster. It generates horizontal and vertical timing, issues one framebuffer read per source pixel with 2x horizontal and vertical doubling, and expands pixels to 24-bit RGB. It sits between the framebuffer BRAM read port and the HDMI/DVI encoder, in the pixel clock domain.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch
- SYNC_POL, 0, active level of hsync_o/vsync_o (0 = active-low)
- FB_WIDTH, 320, framebuffer pixels per line (H_ACTIVE/2)
- clk_i  in  1  pixel clock; sole clock
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  when 0, color outputs forced to 0 and fb_rd_o held 0; timing keeps running
- fb_addr_o  out  17  framebuffer read address
- fb_rd_o  out  1  read strobe; BRAM returns fb_dat_i exactly one cycle later
- fb_dat_i  in  16  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
- red_o / green_o / blue_o  out  8 each  expanded color
- hsync_o, vsync_o  out  1  sync, polarity per SYNC_POL
- de_o  out  1  data enable, high in visible area
- frame_o  out  1  one-cycle pulse at first cycle of vertical blanking

## Operation

- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL = 800), vcnt 0..V_TOTAL-1 (V_TOTAL = 525). hcnt increments every cycle; at H_TOTAL-1 wraps to 0 and vcnt increments; vcnt wraps to 0 after V_TOTAL-1 on the same cycle hcnt wraps.
- Stage 0 (counters): active = hcnt < H_ACTIVE && vcnt < V_ACTIVE. hsync_s0 = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync_s0 = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Addressing without multiplier: line_base register; reset to 0 at vcnt wrap to 0; at hcnt wrap, add FB_WIDTH when the line just finished has vcnt[0]=1 and vcnt < V_ACTIVE. fb_addr_o = line_base + hcnt[9:1], registered. fb_rd_o = active && enable_i, registered. Max address 76799; arithmetic 17 bits, no wrap in range.
- Stage 1: fb_addr_o/fb_rd_o valid; active, hsync, vsync delayed one cycle.
- Stage 2 (outputs): fb_dat_i sampled. If delayed active && enable_i: red_o = {r, r[4:2]}, green_o = {g, g[5:4]}, blue_o = {b, b[4:2]}; else all 0. de_o = delayed active. hsync_o/vsync_o = delayed sync XOR ~SYNC_POL (i.e. driven to SYNC_POL when asserted).
- frame_o: asserted for one cycle when stage-2 aligned counters equal hcnt=0, vcnt=V_ACTIVE.
- Each fb address is read twice per line (doubled pixel) and each line pair reads the same addresses; reads are re-issued, no line buffer.
- enable_i change takes effect on the next read issue; already-fetched pixels in flight are also masked by stage-2 enable check.

## Timing

- Reset values: hcnt=vcnt=0, line_base=0, fb_addr_o=0, fb_rd_o=0, red/green/blue=0, de_o=0, frame_o=0, hsync_o=vsync_o=~SYNC_POL (inactive), all pipeline registers cleared.
- Reset is asynchronous; deassertion mid-frame restarts at (0,0); first de_o high 2 cycles after first clock with rst_i low.
- Latency: counters -> fb_addr_o/fb_rd_o 1 cycle; counters -> color/de/sync outputs 2 cycles. de_o, syncs and colors are mutually aligned.
- Per line: de_o high 640 cycles, hsync active 96 cycles, beginning 16 cycles after de_o falls. Per frame: 480 de lines, vsync active for 2 full lines beginning 10 lines after last active line.
- Frame period 800*525 = 420000 cycles exactly.

## Test plan

- Reset then free run: de_o first rises at cycle 2; 640 high, 160 low per line; hsync_o low for cycles 656..751 of each line (offset +2); frame_o period 420000 cycles.
- Address sequence: line 0 fb_addr_o = 0,0,1,1,...,319,319; line 1 repeats 0..319; line 2 starts at 320; line 479 ends at 76799; no reads outside active area.
- Color expansion: BRAM model returning 16'hf800 -> (255,0,0); 16'h07e0 -> (0,255,0); 16'h001f -> (0,0,255); 16'h0000 -> (0,0,0); 16'h8410 -> (132,130,132).
- Data alignment: BRAM model returning low 16 bits of address; pixel at output x = 2k carries k + line_base, confirming 1-cycle BRAM latency alignment with de_o.
- enable_i low for one full line: fb_rd_o stays 0, colors 0, de_o and syncs unchanged; re-enable restores correct pixels within 2 cycles.
- Asynchronous reset asserted mid-line (hcnt=300, vcnt=100) between clock edges: all outputs return immediately to reset values; after release, frame restarts at address 0.
